// File: rtl/math_pkg.sv
// Shared types for the operand sequencer front end: default width, FSM states, display codes.
package math_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        CALC,
        LATCH,
        SHOW_SUM,
        SHOW_DIFF
    } state_e;

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_SUM  = 2'd2,
        SEL_DIFF = 2'd3
    } disp_sel_e;

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on a rising edge of a level input. IDLE is the assumed previous level
// after reset, so an input already high at reset release does not produce a pulse.
module rise_detect #(
    parameter logic IDLE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) prev <= IDLE;
        else     prev <= in;
    end

    assign pulse = in & ~prev;

endmodule

// File: rtl/operand_sequencer.sv
// Captures A then B from switches, latches math_block results, alternates sum/diff on the display.
// Optional OPERAND_SEQ_OVF_EN adds registered signed-overflow flags ovf_add / ovf_sub.
module operand_sequencer
    import math_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int TOGGLE_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] diff_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             result_valid,
    output logic [WIDTH-1:0] disp_val,
    output logic [1:0]       disp_sel
`ifdef OPERAND_SEQ_OVF_EN
    ,
    output logic             ovf_add,
    output logic             ovf_sub
`endif
);

    localparam int CW = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TOGGLE_CYCLES - 1);

    state_e          state, next_state;
    logic            press;
    logic [WIDTH-1:0] sum_q, diff_q;
    logic [CW-1:0]   counter;
    logic            load_a, load_b, latch_res, cnt_clr, cnt_inc;

    rise_detect #(.IDLE(1'b1)) u_btn_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (btn),
        .pulse (press)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= GET_A;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        latch_res  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        unique case (state)
            GET_A: if (press) begin
                load_a     = 1'b1;
                next_state = GET_B;
            end
            GET_B: if (press) begin
                load_b     = 1'b1;
                next_state = CALC;
            end
            CALC:  next_state = LATCH;
            LATCH: begin
                latch_res  = 1'b1;
                cnt_clr    = 1'b1;
                next_state = SHOW_SUM;
            end
            SHOW_SUM, SHOW_DIFF: begin
                // A press outranks the display toggle when both land on the same cycle.
                if (press) begin
                    cnt_clr    = 1'b1;
                    next_state = GET_A;
                end else if (counter == TERMINAL) begin
                    cnt_clr    = 1'b1;
                    next_state = (state == SHOW_SUM) ? SHOW_DIFF : SHOW_SUM;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: next_state = GET_A;
        endcase
    end

    always_comb begin
        result_valid = 1'b0;
        disp_sel     = SEL_A;
        disp_val     = sw;
        unique case (state)
            GET_A: ;
            GET_B: disp_sel = SEL_B;
            CALC, LATCH: begin
                disp_sel = SEL_B;
                disp_val = B;
            end
            SHOW_SUM: begin
                result_valid = 1'b1;
                disp_sel     = SEL_SUM;
                disp_val     = sum_q;
            end
            SHOW_DIFF: begin
                result_valid = 1'b1;
                disp_sel     = SEL_DIFF;
                disp_val     = diff_q;
            end
            default: ;
        endcase
    end

    // NOTE: this register set is small, so all of it is reset; a retained partial capture would be visible on A/B.
    always_ff @(posedge clk) begin
        if (rst) begin
            A       <= '0;
            B       <= '0;
            sum_q   <= '0;
            diff_q  <= '0;
            counter <= '0;
        end else begin
            if (load_a)    A <= sw;
            if (load_b)    B <= sw;
            if (latch_res) begin
                sum_q  <= sum_in;
                diff_q <= diff_in;
            end
            if (cnt_clr)      counter <= '0;
            else if (cnt_inc) counter <= counter + 1'b1;
        end
    end

`ifdef OPERAND_SEQ_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_add <= 1'b0;
            ovf_sub <= 1'b0;
        end else if (latch_res) begin
            ovf_add <= (A[WIDTH-1] == B[WIDTH-1]) && (sum_in[WIDTH-1]  != A[WIDTH-1]);
            ovf_sub <= (A[WIDTH-1] != B[WIDTH-1]) && (diff_in[WIDTH-1] != A[WIDTH-1]);
        end else if (next_state == GET_A && state != GET_A) begin
            ovf_add <= 1'b0;
            ovf_sub <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with TOGGLE_CYCLES=4; the bench plays math_block itself.
module tb_operand_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw;
    logic         btn;
    logic [W-1:0] sum_in, diff_in;
    logic [W-1:0] A, B, disp_val;
    logic         result_valid;
    logic [1:0]   disp_sel;
`ifdef OPERAND_SEQ_OVF_EN
    logic         ovf_add, ovf_sub;
`endif

    int checks = 0;
    int errors = 0;

    operand_sequencer #(.WIDTH(W), .TOGGLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .btn          (btn),
        .sum_in       (sum_in),
        .diff_in      (diff_in),
        .A            (A),
        .B            (B),
        .result_valid (result_valid),
        .disp_val     (disp_val),
        .disp_sel     (disp_sel)
`ifdef OPERAND_SEQ_OVF_EN
        ,
        .ovf_add      (ovf_add),
        .ovf_sub      (ovf_sub)
`endif
    );

    // Stand-in for math_block: modulo-16 add/subtract of the registered operands.
    assign sum_in  = W'(A + B);
    assign diff_in = W'(A - B);

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic [W-1:0] diff;
        logic         oa;
        logic         os;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle press followed by one low cycle so the next press is a fresh edge.
    task automatic press(input logic [W-1:0] v);
        sw  = v;
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{4'd5,  4'd3, 4'd8,  4'd2,  1'b1, 1'b0};
        vecs[1] = '{4'd2,  4'd7, 4'd9,  4'hB,  1'b1, 1'b0};
        vecs[2] = '{4'd7,  4'd1, 4'd8,  4'd6,  1'b1, 1'b0};
        vecs[3] = '{4'hF,  4'hF, 4'hE,  4'd0,  1'b0, 1'b0};
        vecs[4] = '{4'd0,  4'd1, 4'd1,  4'hF,  1'b0, 1'b0};
        vecs[5] = '{4'd8,  4'd1, 4'd9,  4'd7,  1'b0, 1'b1};

        // Reset with btn held high; releasing reset while btn is high is not a press.
        sw  = 4'd0;
        btn = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        btn = 1'b0;
        repeat (2) tick();
        check("reset_A", A, 0);
        check("reset_B", B, 0);
        check("reset_valid", result_valid, 0);
        check("reset_sel", disp_sel, 0);
`ifdef OPERAND_SEQ_OVF_EN
        check("reset_ovf_add", ovf_add, 0);
        check("reset_ovf_sub", ovf_sub, 0);
`endif
        sw = 4'd6;
        #1;
        check("preview_get_a", disp_val, 6);

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].a);
            check($sformatf("v%0d_A", i), A, vecs[i].a);
            check($sformatf("v%0d_sel_b", i), disp_sel, 1);
            press(vecs[i].b);
            check($sformatf("v%0d_latch_not_valid", i), result_valid, 0);
            tick();
            check($sformatf("v%0d_B", i), B, vecs[i].b);
            check($sformatf("v%0d_valid", i), result_valid, 1);
            check($sformatf("v%0d_sel_sum", i), disp_sel, 2);
            check($sformatf("v%0d_sum", i), disp_val, vecs[i].sum);
`ifdef OPERAND_SEQ_OVF_EN
            check($sformatf("v%0d_ovf_add", i), ovf_add, vecs[i].oa);
            check($sformatf("v%0d_ovf_sub", i), ovf_sub, vecs[i].os);
`endif
            repeat (4) tick();
            check($sformatf("v%0d_sel_diff", i), disp_sel, 3);
            check($sformatf("v%0d_diff", i), disp_val, vecs[i].diff);
            btn = 1'b1;
            tick();
            btn = 1'b0;
            tick();
            check($sformatf("v%0d_back_sel", i), disp_sel, 0);
            check($sformatf("v%0d_back_valid", i), result_valid, 0);
`ifdef OPERAND_SEQ_OVF_EN
            check($sformatf("v%0d_ovf_add_clr", i), ovf_add, 0);
            check($sformatf("v%0d_ovf_sub_clr", i), ovf_sub, 0);
`endif
        end

        // Alternation timing: four cycles per result.
        press(4'd5);
        press(4'd3);
        tick();
        check("tog_sum_0", disp_sel, 2);
        check("tog_sum_val", disp_val, 8);
        repeat (3) tick();
        check("tog_sum_3", disp_sel, 2);
        tick();
        check("tog_diff", disp_sel, 3);
        check("tog_diff_val", disp_val, 2);
        repeat (4) tick();
        check("tog_sum_again", disp_sel, 2);
        check("tog_sum_again_val", disp_val, 8);

        // Press on the terminal count cycle: the press wins.
        repeat (3) tick();
        btn = 1'b1;
        tick();
        check("term_press_sel", disp_sel, 0);
        check("term_press_valid", result_valid, 0);
        btn = 1'b0;
        tick();
        check("term_press_hold_sel", disp_sel, 0);
        check("term_press_A_kept", A, 5);

        // Press landing during CALC/LATCH is ignored; held level is not a repeat press.
        press(4'd2);
        sw  = 4'd7;
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        btn = 1'b1;
        tick();
        check("calc_press_sel", disp_sel, 2);
        check("calc_press_valid", result_valid, 1);
        check("calc_press_sum", disp_val, 9);
        tick();
        check("held_btn_sel", disp_sel, 2);
        btn = 1'b0;
        tick();
        check("released_btn_sel", disp_sel, 2);
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        check("exit_show_sel", disp_sel, 0);

        // Reset mid-operation discards the captured A.
        press(4'd9);
        check("mid_A", A, 9);
        check("mid_sel", disp_sel, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_A", A, 0);
        check("mid_rst_sel", disp_sel, 0);
        check("mid_rst_valid", result_valid, 0);
        rst = 1'b0;
        tick();
        press(4'd4);
        check("post_rst_A", A, 4);
        check("post_rst_sel", disp_sel, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
